bus_master: RTL and testbench
=============================

Name: bus_master

Overview:
- Initiator end of the internal register bus. Converts a simple valid/ready command interface (from a host bridge, e.g. UART command parser or USB endpoint) into single-cycle bus_rd_req/bus_wr_req strobes on bus_in.
- Collects the OR-combined bus_out returned by all bus slaves.
- Returns read data or a write acknowledge, with a timeout error for unmapped addresses.
- Registers the slave IRQ line for the host.

Parameters:
- TIMEOUT, 16, cycles to wait for rd_ack/wr_ack after the strobe before declaring an error (2..255).
- ERR_DATA, 32'hDEADBEEF, value returned on rsp_rdata for a timed-out read.
- Bus widths and field positions come from bus_params.v (BUS_IN_WIDTH, BUS_OUT_WIDTH, BUS_ADDR_WIDTH, BUS_DATA_WIDTH, BUS_FIELD_*); they are not overridden per instance.

Ports:
- bus_clk  in  1  bus clock; forwarded into the clock field of bus_in.
- bus_reset_l  in  1  asynchronous active-low reset; forwarded into the reset field of bus_in.
- bus_in  out  BUS_IN_WIDTH  bus to all slaves: clk, reset_l, addr, wr_data, rd_req, wr_req.
- bus_out  in  BUS_OUT_WIDTH  OR of all slave outputs: rd_data, rd_ack, wr_ack, irq.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block accepts the command this cycle.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  BUS_ADDR_WIDTH  byte address.
- cmd_wdata  in  BUS_DATA_WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  host accepts the response.
- rsp_rdata  out  BUS_DATA_WIDTH  read data; 0 for writes.
- rsp_err  out  1  timeout, no ack received.
- irq  out  1  registered bus irq.

Behaviour:
- Clock and reset: single clock bus_clk; all flops reset asynchronously on bus_reset_l low.
- Reset values:
  - cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, irq=0.
  - Bus addr/wr_data/rd_req/wr_req fields all 0.
- State machine: IDLE, STROBE, WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch cmd_wr/addr/wdata and go to STROBE.
- STROBE (exactly one cycle):
  - Assert rd_req (read) or wr_req (write) for that cycle only.
  - Addr and wr_data are driven from the latched registers and stay stable from STROBE through the end of WAIT.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - Slaves ack one cycle after the strobe, so the earliest ack is the first WAIT cycle.
  - Matching ack (rd_ack for a read, wr_ack for a write):
    - Read: capture bus rd_data into rsp_rdata.
    - Write: rsp_rdata=0.
    - rsp_err=0; go to RESP.
  - Non-matching ack is ignored.
  - On the TIMEOUT-th WAIT cycle with no ack: rsp_err=1; rsp_rdata=ERR_DATA for a read, 0 for a write; go to RESP.
  - An ack in the same cycle the counter expires wins: success.
- RESP:
  - rsp_valid=1; rsp_rdata/rsp_err held stable.
  - On rsp_ready, rsp_valid drops next cycle; go to IDLE.
  - cmd_ready=0 in every non-IDLE state, so only one transaction is outstanding.
- Latency: command accept to rsp_valid is 3 cycles for an immediate-ack slave. Back-to-back throughput is one transaction per 4 cycles when rsp_ready is held high.
- Address: forwarded unmodified. Slaves decode addr[W-1:2], so low bits are don't-care.
- Bus fields outside STROBE/WAIT: addr and wr_data return to 0 in IDLE to reduce toggling. rd_req/wr_req are 0 in every state except STROBE.
- Late ack: an ack arriving after timeout (in RESP or IDLE) is discarded; no state change.
- irq: bus irq field, registered once.
- Reset mid-transaction: returns to IDLE immediately; any in-flight response is lost; no strobe is issued after reset deasserts until a new command arrives.

Decomposition:
- Shared package/include: bus field offsets and widths (existing bus_params.v/bus_decl.v); add the state encoding constants BM_IDLE/BM_STROBE/BM_WAIT/BM_RESP there.
- No sub-module. The timeout counter is inline (8 bits).

Test Plan:
- Read, immediate ack: slave at 0x10 returns 0x12345678 one cycle after the strobe; cmd read 0x10 → rd_req high exactly 1 cycle, rsp_valid on cycle 3, rsp_rdata=0x12345678, rsp_err=0.
- Write: cmd write 0x20 data 0xA5A5A5A5 → wr_req 1 cycle with addr=0x20 and wr_data=0xA5A5A5A5 stable until wr_ack; rsp_err=0, rsp_rdata=0.
- Unmapped read at 0x3FC, TIMEOUT=16 → rsp_valid exactly 16 WAIT cycles after the strobe, rsp_rdata=0xDEADBEEF, rsp_err=1. Inject an ack 2 cycles later → ignored, no second response.
- Backpressure: hold rsp_ready=0 for 10 cycles while cmd_valid stays high → rsp held stable, cmd_ready=0 throughout, no extra strobe. Then release rsp_ready → the next command is accepted the cycle after returning to IDLE.
- Reset during WAIT: assert bus_reset_l=0 → all outputs 0 asynchronously (before the next edge); after release, cmd_ready=1 and no strobe occurs without a new command.
- IRQ and boundary: drive bus irq high → irq high one cycle later. Ack arriving on the exact expiry cycle → rsp_err=0 with the captured data.

Source files
------------

// File: rtl/bus_master_pkg.sv
// Shared register-bus definitions: field layout of bus_in/bus_out and master FSM encoding.
package bus_master_pkg;

    localparam int unsigned BUS_ADDR_WIDTH = 16;
    localparam int unsigned BUS_DATA_WIDTH = 32;

    // bus_in layout (LSB first): clk, reset_l, addr, wr_data, rd_req, wr_req
    localparam int unsigned BUS_FIELD_CLK     = 0;
    localparam int unsigned BUS_FIELD_RESET_L = 1;
    localparam int unsigned BUS_FIELD_ADDR    = 2;
    localparam int unsigned BUS_FIELD_WR_DATA = BUS_FIELD_ADDR + BUS_ADDR_WIDTH;
    localparam int unsigned BUS_FIELD_RD_REQ  = BUS_FIELD_WR_DATA + BUS_DATA_WIDTH;
    localparam int unsigned BUS_FIELD_WR_REQ  = BUS_FIELD_RD_REQ + 1;
    localparam int unsigned BUS_IN_WIDTH      = BUS_FIELD_WR_REQ + 1;

    // bus_out layout (LSB first): rd_data, rd_ack, wr_ack, irq
    localparam int unsigned BUS_FIELD_RD_DATA = 0;
    localparam int unsigned BUS_FIELD_RD_ACK  = BUS_DATA_WIDTH;
    localparam int unsigned BUS_FIELD_WR_ACK  = BUS_FIELD_RD_ACK + 1;
    localparam int unsigned BUS_FIELD_IRQ     = BUS_FIELD_WR_ACK + 1;
    localparam int unsigned BUS_OUT_WIDTH     = BUS_FIELD_IRQ + 1;

    typedef enum logic [1:0] {
        BM_IDLE   = 2'd0,
        BM_STROBE = 2'd1,
        BM_WAIT   = 2'd2,
        BM_RESP   = 2'd3
    } bm_state_e;

    // Assemble the bus_in vector in field order.
    function automatic logic [BUS_IN_WIDTH-1:0] pack_bus_in(
        input logic                      clk,
        input logic                      reset_l,
        input logic [BUS_ADDR_WIDTH-1:0] addr,
        input logic [BUS_DATA_WIDTH-1:0] wr_data,
        input logic                      rd_req,
        input logic                      wr_req
    );
        return {wr_req, rd_req, wr_data, addr, reset_l, clk};
    endfunction

endpackage

// File: rtl/bus_master_if.sv
// Command/response handshake plus register-bus vectors seen by the bus master.
interface bus_master_if;
    import bus_master_pkg::*;

    logic [BUS_IN_WIDTH-1:0]   bus_in;
    logic [BUS_OUT_WIDTH-1:0]  bus_out;
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_wr;
    logic [BUS_ADDR_WIDTH-1:0] cmd_addr;
    logic [BUS_DATA_WIDTH-1:0] cmd_wdata;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [BUS_DATA_WIDTH-1:0] rsp_rdata;
    logic                      rsp_err;
    logic                      irq;

    modport master (
        output bus_in, cmd_ready, rsp_valid, rsp_rdata, rsp_err, irq,
        input  bus_out, cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready
    );

    modport slave (
        input  bus_in, cmd_ready, rsp_valid, rsp_rdata, rsp_err, irq,
        output bus_out, cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready
    );

endinterface

// File: rtl/bus_master.sv
// Register-bus initiator: one outstanding command, single-cycle strobe, ack wait with
// timeout, held response, registered slave irq.
module bus_master
    import bus_master_pkg::*;
#(
    parameter int unsigned               TIMEOUT  = 16,
    parameter logic [BUS_DATA_WIDTH-1:0] ERR_DATA = 32'hDEADBEEF
) (
    input logic          i_bus_clk,
    input logic          i_bus_reset_l,
    bus_master_if.master if_bus
);

    bm_state_e                 r_state, w_state_next;
    logic                      r_run;
    logic                      r_wr, w_wr_next;
    logic [BUS_ADDR_WIDTH-1:0] r_addr, w_addr_next;
    logic [BUS_DATA_WIDTH-1:0] r_wdata, w_wdata_next;
    logic [7:0]                r_cnt, w_cnt_next;
    logic [BUS_DATA_WIDTH-1:0] r_rdata, w_rdata_next;
    logic                      r_err, w_err_next;
    logic                      r_irq;

    logic                      w_cmd_ready;
    logic                      w_ack;
    logic                      w_expired;
    logic                      w_drive;
    logic                      w_strobe;
    logic [BUS_DATA_WIDTH-1:0] w_bus_rdata;

    // r_run keeps cmd_ready low while reset is held and until the first edge after release.
    assign w_cmd_ready = r_run && (r_state == BM_IDLE);
    assign w_bus_rdata = if_bus.bus_out[BUS_FIELD_RD_DATA +: BUS_DATA_WIDTH];
    assign w_ack       = r_wr ? if_bus.bus_out[BUS_FIELD_WR_ACK] : if_bus.bus_out[BUS_FIELD_RD_ACK];
    assign w_expired   = (r_cnt == 8'(TIMEOUT - 1));
    assign w_drive     = (r_state == BM_STROBE) || (r_state == BM_WAIT);
    assign w_strobe    = (r_state == BM_STROBE);

    // State and datapath registers.
    always_ff @(posedge i_bus_clk or negedge i_bus_reset_l) begin
        if (!i_bus_reset_l) begin
            r_state <= BM_IDLE;
            r_run   <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_run   <= 1'b1;
            r_wr    <= w_wr_next;
            r_addr  <= w_addr_next;
            r_wdata <= w_wdata_next;
            r_cnt   <= w_cnt_next;
            r_rdata <= w_rdata_next;
            r_err   <= w_err_next;
            r_irq   <= if_bus.bus_out[BUS_FIELD_IRQ];
        end
    end

    // Next-state logic: accept, strobe, wait for matching ack or timeout, hold response.
    always_comb begin
        w_state_next = r_state;
        w_wr_next    = r_wr;
        w_addr_next  = r_addr;
        w_wdata_next = r_wdata;
        w_cnt_next   = r_cnt;
        w_rdata_next = r_rdata;
        w_err_next   = r_err;
        unique case (r_state)
            BM_IDLE: begin
                if (w_cmd_ready && if_bus.cmd_valid) begin
                    w_wr_next    = if_bus.cmd_wr;
                    w_addr_next  = if_bus.cmd_addr;
                    w_wdata_next = if_bus.cmd_wdata;
                    w_state_next = BM_STROBE;
                end
            end
            BM_STROBE: begin
                w_cnt_next   = '0;
                w_state_next = BM_WAIT;
            end
            BM_WAIT: begin
                // An ack on the expiry cycle is checked first, so it counts as success.
                if (w_ack) begin
                    w_rdata_next = r_wr ? '0 : w_bus_rdata;
                    w_err_next   = 1'b0;
                    w_state_next = BM_RESP;
                end else if (w_expired) begin
                    w_rdata_next = r_wr ? '0 : ERR_DATA;
                    w_err_next   = 1'b1;
                    w_state_next = BM_RESP;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            BM_RESP: begin
                if (if_bus.rsp_ready) begin
                    w_state_next = BM_IDLE;
                end
            end
            default: w_state_next = BM_IDLE;
        endcase
    end

    // Outputs: addr/wr_data only driven during STROBE/WAIT, strobes only in STROBE.
    always_comb begin
        if_bus.cmd_ready = w_cmd_ready;
        if_bus.rsp_valid = (r_state == BM_RESP);
        if_bus.rsp_rdata = r_rdata;
        if_bus.rsp_err   = r_err;
        if_bus.irq       = r_irq;
        if_bus.bus_in    = pack_bus_in(i_bus_clk, i_bus_reset_l,
                                       w_drive ? r_addr : '0,
                                       w_drive ? r_wdata : '0,
                                       w_strobe && !r_wr,
                                       w_strobe && r_wr);
    end

endmodule

// File: tb/tb_bus_master.sv
// Directed bench for bus_master with an expected-response scoreboard.
module tb_bus_master;
    import bus_master_pkg::*;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic clk   = 1'b0;
    logic rst_l = 1'b0;
    logic tb_irq = 1'b0;
    rsp_t sb[$];
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    bus_master_if u_if();

    bus_master #(
        .TIMEOUT  (16),
        .ERR_DATA (32'hDEADBEEF)
    ) dut (
        .i_bus_clk     (clk),
        .i_bus_reset_l (rst_l),
        .if_bus        (u_if)
    );

    logic        w_rd_req, w_wr_req, w_reset_fld;
    logic [15:0] w_addr;
    logic [31:0] w_wdata;
    assign w_rd_req    = u_if.bus_in[BUS_FIELD_RD_REQ];
    assign w_wr_req    = u_if.bus_in[BUS_FIELD_WR_REQ];
    assign w_reset_fld = u_if.bus_in[BUS_FIELD_RESET_L];
    assign w_addr      = u_if.bus_in[BUS_FIELD_ADDR +: BUS_ADDR_WIDTH];
    assign w_wdata     = u_if.bus_in[BUS_FIELD_WR_DATA +: BUS_DATA_WIDTH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_out(input logic [31:0] data, input logic rd_ack, input logic wr_ack);
        u_if.bus_out = {tb_irq, wr_ack, rd_ack, data};
    endtask

    task automatic push(input logic [31:0] rdata, input logic err);
        rsp_t e;
        e.rdata = rdata;
        e.err   = err;
        sb.push_back(e);
    endtask

    // Present a command in IDLE; returns at the negedge of the STROBE cycle.
    task automatic issue(input string tag, input logic wr, input logic [15:0] addr,
                         input logic [31:0] data);
        u_if.cmd_wr    = wr;
        u_if.cmd_addr  = addr;
        u_if.cmd_wdata = data;
        u_if.cmd_valid = 1'b1;
        chk({tag, "_cmd_ready"}, u_if.cmd_ready, 1'b1);
        tick();
        u_if.cmd_valid = 1'b0;
        chk({tag, "_strobe"}, {w_rd_req, w_wr_req}, {~wr, wr});
        chk({tag, "_strobe_addr"}, w_addr, addr);
        if (wr) chk({tag, "_strobe_wdata"}, w_wdata, data);
    endtask

    // Compare the current response with the scoreboard head, then hand it off.
    task automatic pop_rsp(input string tag);
        rsp_t e;
        chk({tag, "_rsp_valid"}, u_if.rsp_valid, 1'b1);
        chk({tag, "_sb_depth"}, sb.size(), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_rsp_rdata"}, u_if.rsp_rdata, e.rdata);
            chk({tag, "_rsp_err"}, u_if.rsp_err, e.err);
        end
        u_if.rsp_ready = 1'b1;
        tick();
        u_if.rsp_ready = 1'b0;
        chk({tag, "_rsp_drop"}, u_if.rsp_valid, 1'b0);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!u_if.rsp_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int seen;
        u_if.cmd_valid = 1'b0;
        u_if.cmd_wr    = 1'b0;
        u_if.cmd_addr  = '0;
        u_if.cmd_wdata = '0;
        u_if.rsp_ready = 1'b0;
        set_out(32'h0, 1'b0, 1'b0);

        // Reset values
        tick();
        tick();
        chk("rst_cmd_ready", u_if.cmd_ready, 1'b0);
        chk("rst_rsp_valid", u_if.rsp_valid, 1'b0);
        chk("rst_rsp_rdata", u_if.rsp_rdata, 32'h0);
        chk("rst_irq", u_if.irq, 1'b0);
        chk("rst_bus_fields", {w_addr, w_wdata, w_rd_req, w_wr_req, w_reset_fld}, 51'h0);
        rst_l = 1'b1;
        tick();
        tick();

        // Read with immediate ack: rsp_valid three cycles after accept
        push(32'h12345678, 1'b0);
        issue("rd", 1'b0, 16'h0010, 32'h0);
        tick();
        chk("rd_strobe_once", {w_rd_req, w_wr_req}, 2'b00);
        chk("rd_addr_wait", w_addr, 16'h0010);
        set_out(32'h12345678, 1'b1, 1'b0);
        tick();
        set_out(32'h0, 1'b0, 1'b0);
        pop_rsp("rd");

        // Write with a stray rd_ack first, then wr_ack two cycles after the strobe
        push(32'h0, 1'b0);
        issue("wr", 1'b1, 16'h0020, 32'hA5A5A5A5);
        tick();
        chk("wr_hold1", {w_wr_req, w_addr, w_wdata}, {1'b0, 16'h0020, 32'hA5A5A5A5});
        set_out(32'hFFFF0000, 1'b1, 1'b0);
        tick();
        chk("wr_hold2", {w_wr_req, w_addr, w_wdata}, {1'b0, 16'h0020, 32'hA5A5A5A5});
        chk("wr_nonmatch_ignored", u_if.rsp_valid, 1'b0);
        set_out(32'h00000077, 1'b0, 1'b1);
        tick();
        set_out(32'h0, 1'b0, 1'b0);
        pop_rsp("wr");
        chk("idle_bus_zero", {w_addr, w_wdata}, 48'h0);

        // Unmapped read: timeout after 16 WAIT cycles, late ack discarded
        push(32'hDEADBEEF, 1'b1);
        issue("to", 1'b0, 16'h03FC, 32'h0);
        wait_valid(n);
        chk("to_latency", n, 17);
        set_out(32'h55555555, 1'b1, 1'b0);
        tick();
        chk("to_late_ack_resp", {u_if.rsp_valid, u_if.rsp_err, u_if.rsp_rdata},
            {1'b1, 1'b1, 32'hDEADBEEF});
        set_out(32'h0, 1'b0, 1'b0);
        pop_rsp("to");
        set_out(32'h55555555, 1'b1, 1'b0);
        tick();
        tick();
        chk("to_late_ack_idle", {u_if.rsp_valid, w_rd_req, w_wr_req, u_if.cmd_ready}, 4'b0001);
        set_out(32'h0, 1'b0, 1'b0);

        // Backpressure with cmd_valid held high across the response
        push(32'hCAFEF00D, 1'b0);
        u_if.cmd_wr    = 1'b0;
        u_if.cmd_addr  = 16'h0010;
        u_if.cmd_valid = 1'b1;
        chk("bp_cmd_ready", u_if.cmd_ready, 1'b1);
        tick();
        u_if.cmd_wr    = 1'b1;
        u_if.cmd_addr  = 16'h0044;
        u_if.cmd_wdata = 32'h01020304;
        chk("bp_strobe", {w_rd_req, u_if.cmd_ready}, 2'b10);
        tick();
        set_out(32'hCAFEF00D, 1'b1, 1'b0);
        tick();
        set_out(32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold", {u_if.rsp_valid, u_if.cmd_ready, w_rd_req | w_wr_req, u_if.rsp_rdata},
                {1'b1, 1'b0, 1'b0, 32'hCAFEF00D});
            tick();
        end
        pop_rsp("bp");
        chk("bp_next_ready", u_if.cmd_ready, 1'b1);
        push(32'h0, 1'b0);
        tick();
        u_if.cmd_valid = 1'b0;
        chk("bp_next_strobe", {w_wr_req, w_addr, w_wdata}, {1'b1, 16'h0044, 32'h01020304});
        tick();
        set_out(32'h0, 1'b0, 1'b1);
        tick();
        set_out(32'h0, 1'b0, 1'b0);
        pop_rsp("bp2");

        // IRQ is registered once
        tb_irq = 1'b1;
        set_out(32'h0, 1'b0, 1'b0);
        #1;
        chk("irq_not_yet", u_if.irq, 1'b0);
        tick();
        chk("irq_reg", u_if.irq, 1'b1);

        // Ack on the exact expiry cycle wins
        push(32'h0BADF00D, 1'b0);
        issue("exp", 1'b0, 16'h03FC, 32'h0);
        for (int i = 0; i < 16; i++) tick();
        chk("exp_not_valid", u_if.rsp_valid, 1'b0);
        set_out(32'h0BADF00D, 1'b1, 1'b0);
        tick();
        set_out(32'h0, 1'b0, 1'b0);
        pop_rsp("exp");

        // Reset during WAIT: outputs clear before the next edge
        issue("rw", 1'b0, 16'h0080, 32'h0);
        tick();
        #2;
        rst_l = 1'b0;
        #1;
        chk("rw_async_outs", {u_if.rsp_valid, u_if.cmd_ready, u_if.irq, u_if.rsp_err,
                              u_if.rsp_rdata}, 36'h0);
        chk("rw_async_bus", {w_addr, w_rd_req, w_wr_req}, 18'h0);
        tb_irq = 1'b0;
        set_out(32'h0, 1'b0, 1'b0);
        tick();
        rst_l = 1'b1;
        tick();
        chk("rw_ready_after", u_if.cmd_ready, 1'b1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (w_rd_req || w_wr_req || u_if.rsp_valid) seen++;
            tick();
        end
        chk("rw_no_strobe", seen, 0);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
